tx_dma_blk_writer: RTL
======================

# tx_dma_blk_writer

Drains 4KB blocks from the link-arbiter FIFO and emits them as PCIe memory-write TLPs on the HIP TX stream. Each block is written into a per-link host ring buffer. The block sits directly downstream of the link arbiter and consumes its show-ahead data FIFO and link-number FIFO. It also returns the block-done pulse to the arbiter and the per-link block-done indication used for flush accounting.

## Interface
Parameters:
- PORTS, 12, number of links
- PORT_WIDTH, $clog2(PORTS), link-number width
- MPS_BEATS, 8, 256-bit beats per TLP; legal values 4/8/16 (128/256/512 B)

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iFIFO_DATA  in  256  show-ahead FIFO head data
- iFIFO_EMPTY  in  1  FIFO empty
- iFIFO_USED  in  8  FIFO occupancy in beats
- iLINK_NUMBER  in  PORT_WIDTH  link owning the head block
- oFIFO_RD_ACK  out  1  pop one beat
- oBLK_DONE_PULSE  out  1  one-cycle pulse; pops the link-number FIFO
- oHIP_BLK_DONE  out  1  one-cycle pulse, coincident with oBLK_DONE_PULSE
- oHIP_LINK_NUMBER  out  PORT_WIDTH  link of the completed block; valid with oHIP_BLK_DONE
- iREG_EN  in  1  enable new blocks
- iREG_RING_BASE  in  [PORTS-1:0][63:0]  per-link ring base; 4KB aligned
- iREG_RING_BLKS  in  [PORTS-1:0][15:0]  ring size in 4KB blocks; 0 is treated as 1
- oTX_HDR  out  128  header sideband; valid with oTX_SOP
- oTX_DATA  out  256  payload
- oTX_VALID / oTX_SOP / oTX_EOP  out  1 each  stream qualifiers
- iTX_READY  in  1  HIP accepts beat when VALID&READY
- oREG_WR_PTR  out  [PORTS-1:0][15:0]  per-link ring write pointer

## Operation
- TLPS = 128/MPS_BEATS per block; tlp_cnt counts TLPs and beat_cnt counts beats within a TLP.
- FSM states IDLE, XFER, BLK_DONE.
- IDLE → XFER when iFIFO_USED ≥ MPS_BEATS and either tlp_cnt≠0 (block in progress) or iREG_EN=1.
  - On the first TLP of a block, iLINK_NUMBER is latched into cur_link and held for the whole block.
  - oTX_HDR is registered on this transition.
- XFER: oTX_VALID=1 and oTX_DATA=iFIFO_DATA (combinational); oFIFO_RD_ACK=oTX_VALID&iTX_READY.
  - oTX_SOP = (beat_cnt==0); oTX_EOP = (beat_cnt==MPS_BEATS-1).
- On an EOP accept: go to BLK_DONE if tlp_cnt==TLPS-1, else go to IDLE with tlp_cnt+1.
- BLK_DONE (one cycle): assert oBLK_DONE_PULSE and oHIP_BLK_DONE; oHIP_LINK_NUMBER=cur_link.
  - wr_ptr[cur_link] becomes 0 if wr_ptr ≥ max(blks,1)-1, else wr_ptr+1.
  - tlp_cnt becomes 0; next state IDLE.
- oTX_HDR fields:
  - [127:64] = base + {wr_ptr,12'h0} + tlp_cnt*MPS_BEATS*32, with 64-bit wrap.
  - [9:0] = MPS_BEATS*8 DW.
  - [23:16] = tlp_cnt.
  - [31:24] = cur_link, zero-extended.
  - All other bits 0.
- iREG_EN deasserted mid-block: the current block completes; no new block starts.
- iFIFO_EMPTY is never read while oTX_VALID=1, because the XFER entry condition guarantees data. Bench asserts !(oFIFO_RD_ACK & iFIFO_EMPTY).

## Timing
- Reset values: all outputs 0; FSM in IDLE; counters and wr_ptr 0.
- Reset mid-TLP aborts immediately. Upstream is reset on the same iRST.
- Latency: SOP appears 1 cycle after the entry condition is met. READY→pop is 0 cycles.
- Backpressure: iTX_READY=0 holds all stream outputs stable.
- Minimum gap between TLPs: 1 cycle (IDLE). Minimum gap between blocks: 2 cycles (BLK_DONE, IDLE).
- Block-done pulses occur 1 cycle after the last EOP accept.

## Configuration
- TX_DMA_BLK_WRITER_STALL_CTR_EN defined: adds output oREG_STALL_CTR[31:0].
  - Counts cycles with oTX_VALID&~iTX_READY; saturates at all-ones; reset 0.
- Not defined: the port and the counter are absent; all other behaviour is unchanged.

## Structure
- bali_lib_pkg holds:
  - the state enum tx_dma_blk_writer_state_e;
  - BLK_BYTES=4096, BEAT_BYTES=32, BLK_BEATS=128;
  - the function building the 128-bit write header.
- One sub-module: tx_dma_ring_ptr, the per-link wr_ptr array with wrap logic and advance strobe.

## Test plan
- Single block, link 3, base 0x1_0000_0000, blks 4, MPS 8, READY=1:
  - 16 TLPs at addresses 0x1_0000_0000 + n*0x100, each with length 64 DW;
  - one oHIP_BLK_DONE with link 3; wr_ptr[3]=1.
- Five blocks on link 0 with blks=4: the 5th block starts at base+0x0 (wrap); wr_ptr[0] reaches 1.
- READY toggled 50% randomly: payload is bit-exact; no pop while READY=0; exactly 128 pops per block.
- iREG_EN dropped after TLP 5: all 16 TLPs still issued, then IDLE held while the FIFO is non-empty.
- iFIFO_USED=7 held: no SOP. Raise to 8: SOP on the next cycle.
- iRST asserted mid-TLP: next cycle all outputs 0, FSM IDLE, wr_ptr all 0.

Source files
------------

// File: rtl/bali_lib_pkg.sv
// Shared types and helpers for the TX DMA block writer: FSM states, block geometry,
// memory-write header construction and host-ring pointer wrap.
package bali_lib_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    BLK_DONE = 2'd2
  } tx_dma_blk_writer_state_e;

  localparam int BLK_BYTES  = 4096;
  localparam int BEAT_BYTES = 32;
  localparam int BLK_BEATS  = BLK_BYTES / BEAT_BYTES;

  // Address is the ring slot of this block plus the byte offset of the TLP within it.
  function automatic logic [127:0] build_wr_hdr(
    input logic [63:0]  base,
    input logic [15:0]  wr_ptr,
    input logic [7:0]   tlp_idx,
    input logic [7:0]   link,
    input int unsigned  mps_beats
  );
    logic [63:0]  addr;
    logic [127:0] hdr;
    addr = base + {36'd0, wr_ptr, 12'd0}
         + (64'(tlp_idx) * 64'(mps_beats) * 64'(BEAT_BYTES));
    hdr          = 128'd0;
    hdr[127:64]  = addr;
    hdr[31:24]   = link;
    hdr[23:16]   = tlp_idx;
    hdr[9:0]     = 10'(mps_beats * 32'd8);
    return hdr;
  endfunction

  // A ring size of zero behaves as a single-block ring.
  function automatic logic [15:0] ring_next(
    input logic [15:0] ptr,
    input logic [15:0] blks
  );
    logic [15:0] last;
    last = (blks == 16'd0) ? 16'd0 : (blks - 16'd1);
    return (ptr >= last) ? 16'd0 : (ptr + 16'd1);
  endfunction

endpackage

// File: rtl/tx_dma_ring_ptr.sv
// Per-link host ring write pointers; the selected link advances (with wrap) on iADV.
module tx_dma_ring_ptr
  import bali_lib_pkg::*;
#(
  parameter int PORTS      = 12,
  parameter int PORT_WIDTH = $clog2(PORTS)
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iADV,
  input  logic [PORT_WIDTH-1:0]       iADV_LINK,
  input  logic [PORTS-1:0][15:0]      iRING_BLKS,
  output logic [PORTS-1:0][15:0]      oWR_PTR
);

  logic [PORTS-1:0][15:0] wr_ptr_q, wr_ptr_d;

  // Next pointer for every link; only the advancing link moves.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < PORTS; i++) begin
      if (iADV && (iADV_LINK == PORT_WIDTH'(i))) begin
        wr_ptr_d[i] = ring_next(wr_ptr_q[i], iRING_BLKS[i]);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign oWR_PTR = wr_ptr_q;

endmodule

// File: rtl/tx_dma_blk_writer.sv
// Drains 4KB blocks from the link-arbiter FIFO as PCIe memory-write TLPs into per-link rings.
// Optional stall counter output enabled by defining TX_DMA_BLK_WRITER_STALL_CTR_EN.
module tx_dma_blk_writer
  import bali_lib_pkg::*;
#(
  parameter int PORTS      = 12,
  parameter int PORT_WIDTH = $clog2(PORTS),
  parameter int MPS_BEATS  = 8
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [255:0]                iFIFO_DATA,
  input  logic                        iFIFO_EMPTY,
  input  logic [7:0]                  iFIFO_USED,
  input  logic [PORT_WIDTH-1:0]       iLINK_NUMBER,
  output logic                        oFIFO_RD_ACK,
  output logic                        oBLK_DONE_PULSE,
  output logic                        oHIP_BLK_DONE,
  output logic [PORT_WIDTH-1:0]       oHIP_LINK_NUMBER,
  input  logic                        iREG_EN,
  input  logic [PORTS-1:0][63:0]      iREG_RING_BASE,
  input  logic [PORTS-1:0][15:0]      iREG_RING_BLKS,
  output logic [127:0]                oTX_HDR,
  output logic [255:0]                oTX_DATA,
  output logic                        oTX_VALID,
  output logic                        oTX_SOP,
  output logic                        oTX_EOP,
  input  logic                        iTX_READY,
  output logic [PORTS-1:0][15:0]      oREG_WR_PTR
`ifdef TX_DMA_BLK_WRITER_STALL_CTR_EN
  ,
  output logic [31:0]                 oREG_STALL_CTR
`endif
);

  localparam int        TLPS      = BLK_BEATS / MPS_BEATS;
  localparam logic [4:0] LAST_BEAT = 5'(MPS_BEATS - 1);
  localparam logic [7:0] LAST_TLP  = 8'(TLPS - 1);

  tx_dma_blk_writer_state_e state_q, state_d;
  logic [4:0]            beat_cnt_q, beat_cnt_d;
  logic [7:0]            tlp_cnt_q, tlp_cnt_d;
  logic [PORT_WIDTH-1:0] cur_link_q, cur_link_d;
  logic [127:0]          hdr_q, hdr_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  done_q, done_d;
  logic [PORT_WIDTH-1:0] hip_link_q, hip_link_d;

  logic [PORTS-1:0][15:0] wr_ptr_s;
  logic [PORT_WIDTH-1:0]  hdr_link_s;
  logic                   start_s;

  // The first TLP of a block takes its link from the FIFO head; later ones reuse the latched link.
  assign hdr_link_s = (tlp_cnt_q == 8'd0) ? iLINK_NUMBER : cur_link_q;
  assign start_s    = !iFIFO_EMPTY && (iFIFO_USED >= 8'(MPS_BEATS))
                   && ((tlp_cnt_q != 8'd0) || iREG_EN);

  // Next-state, counters and registered stream/done qualifiers.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    tlp_cnt_d  = tlp_cnt_q;
    cur_link_d = cur_link_q;
    hdr_d      = hdr_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d    = XFER;
          beat_cnt_d = 5'd0;
          cur_link_d = hdr_link_s;
          hdr_d      = build_wr_hdr(iREG_RING_BASE[hdr_link_s], wr_ptr_s[hdr_link_s],
                                    tlp_cnt_q, 8'(hdr_link_s), MPS_BEATS);
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (iTX_READY) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = 5'd0;
            if (tlp_cnt_q == LAST_TLP) begin
              state_d = BLK_DONE;
            end else begin
              tlp_cnt_d = tlp_cnt_q + 8'd1;
              state_d   = IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end else begin
          state_d = XFER;
        end
      end
      BLK_DONE: begin
        tlp_cnt_d = 8'd0;
        state_d   = IDLE;
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = 5'd0;
        tlp_cnt_d  = 8'd0;
      end
    endcase
    valid_d    = (state_d == XFER);
    sop_d      = valid_d && (beat_cnt_d == 5'd0);
    eop_d      = valid_d && (beat_cnt_d == LAST_BEAT);
    done_d     = (state_d == BLK_DONE);
    hip_link_d = done_d ? cur_link_d : '0;
  end

  // FSM and output registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      beat_cnt_q <= 5'd0;
      tlp_cnt_q  <= 8'd0;
      cur_link_q <= '0;
      hdr_q      <= 128'd0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      done_q     <= 1'b0;
      hip_link_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      tlp_cnt_q  <= tlp_cnt_d;
      cur_link_q <= cur_link_d;
      hdr_q      <= hdr_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      done_q     <= done_d;
      hip_link_q <= hip_link_d;
    end
  end

  tx_dma_ring_ptr #(
    .PORTS      (PORTS),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_ring_ptr (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iADV       (state_q == BLK_DONE),
    .iADV_LINK  (cur_link_q),
    .iRING_BLKS (iREG_RING_BLKS),
    .oWR_PTR    (wr_ptr_s)
  );

  // Payload is the show-ahead head; popping it is the accept itself.
  assign oTX_DATA         = valid_q ? iFIFO_DATA : 256'd0;
  assign oFIFO_RD_ACK     = valid_q & iTX_READY;
  assign oTX_VALID        = valid_q;
  assign oTX_SOP          = sop_q;
  assign oTX_EOP          = eop_q;
  assign oTX_HDR          = hdr_q;
  assign oBLK_DONE_PULSE  = done_q;
  assign oHIP_BLK_DONE    = done_q;
  assign oHIP_LINK_NUMBER = hip_link_q;
  assign oREG_WR_PTR      = wr_ptr_s;

`ifdef TX_DMA_BLK_WRITER_STALL_CTR_EN
  logic [31:0] stall_ctr_q, stall_ctr_d;

  // Backpressure cycle counter, saturating.
  always_comb begin
    stall_ctr_d = stall_ctr_q;
    if (valid_q && !iTX_READY && (stall_ctr_q != 32'hFFFF_FFFF)) begin
      stall_ctr_d = stall_ctr_q + 32'd1;
    end else begin
      stall_ctr_d = stall_ctr_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stall_ctr_q <= 32'd0;
    end else begin
      stall_ctr_q <= stall_ctr_d;
    end
  end

  assign oREG_STALL_CTR = stall_ctr_q;
`endif

endmodule
